hi_lo_muldiv: RTL and testbench
===============================

HI_LO_MULDIV -- requirements
Module: hi_lo_muldiv

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of multiply/divide iteration cycles; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  issue strobe; the current alu_control, operands and enables are valid this cycle.
REQ-005 SHALL have port alu_control  input  5  ALU control code: MULT=10000, MULTU=10001, DIV=10010, DIVU=10011, MTLO=10101, MTHI=10110; all other codes are ignored.
REQ-006 SHALL have port op_a  input  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 SHALL have port op_b  input  32  rt value: multiplier or divisor.
REQ-008 SHALL have port LO_write_enable  input  1  LO write permission from the decoder.
REQ-009 SHALL have port HI_write_enable  input  1  HI write permission from the decoder.
REQ-010 SHALL have port busy  output  1  high while a mul/div is in flight; the CPU stalls on it.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a mul/div result is committed.
REQ-012 SHALL have port hi  output  32  HI register.
REQ-013 SHALL have port lo  output  32  LO register.

Function
REQ-014 An op SHALL be accepted only when start=1 and the state is IDLE; start while not IDLE SHALL be ignored, with no queuing.
REQ-015 MTHI accepted SHALL set hi<=op_a at that edge, gated by HI_write_enable; MTLO accepted SHALL set lo<=op_a, gated by LO_write_enable; neither SHALL assert busy or done.
REQ-016 MULT/MULTU/DIV/DIVU accepted SHALL latch op_a, op_b and the opcode, and SHALL move IDLE->RUN with iteration counter=0, provided both enables are 1; otherwise the op is ignored.
REQ-017 The FSM states SHALL be IDLE, RUN and FIX; RUN performs one iteration per cycle and goes to FIX after iteration 31 completes; FIX goes to IDLE after one cycle.
REQ-018 Multiply SHALL be a shift-add over 32 iterations on operand magnitudes, with a 64-bit accumulator.
REQ-019 Divide SHALL be restoring division over 32 iterations on magnitudes, producing a 32-bit quotient and a 32-bit remainder.
REQ-020 For signed ops, FIX SHALL negate the product if sign(a)^sign(b); the quotient SHALL take sign sign(a)^sign(b); the remainder SHALL take sign(a); all arithmetic SHALL be mod 2^32.
REQ-021 At the FIX edge the block SHALL write hi<=product[63:32] and lo<=product[31:0], or hi<=remainder and lo<=quotient; hi and lo are written atomically.
REQ-022 hi and lo SHALL hold their old values throughout RUN.
REQ-023 busy SHALL be 1 exactly while state!=IDLE.
REQ-024 done SHALL be registered, =1 in the single cycle after the FIX edge.
REQ-025 Latency: for a mul/div accepted at edge E0, results SHALL be visible and done=1 after edge E33.
REQ-026 DIV/DIVU with op_b=0 SHALL NOT enter RUN; hi and lo SHALL be unchanged and done SHALL pulse in the cycle after acceptance.
REQ-027 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-028 An MTHI/MTLO or a mul/div issued in the same cycle as the FIX commit SHALL be ignored, since the state is not IDLE.

Reset
REQ-029 reset=0 SHALL immediately, independent of clk, force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and clear all operand and accumulator registers.
REQ-030 Reset during RUN or FIX SHALL abort the op with no result committed and no done pulse.
REQ-031 The first op after reset deasserts SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once, busy high for 33 cycles.
REQ-033 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 7/2 -> hi=1, lo=3.
REQ-034 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIV with b=0 and hi=0x1234, lo=0x5678 -> values unchanged, busy never 1, done=1 on the next cycle.
REQ-036 With MULT in flight, issue MTHI a=0xAAAA and a second DIVU -> both ignored; final hi/lo equal the MULT result only.
REQ-037 Assert reset at RUN iteration 10 -> busy=0, hi=lo=0 immediately, no done; a new MULTU 3*4 afterwards yields lo=12, hi=0.

Source files
------------

// File: rtl/hi_lo_muldiv.sv
// hi_lo_muldiv: HI/LO register file with an iterative multiply/divide unit.
//
// Multiplies use a 32-cycle shift-add on operand magnitudes into a 64-bit
// accumulator. Divides use a 32-cycle restoring algorithm on magnitudes.
// Signs are fixed up in a single FIX cycle, which also commits HI and LO
// together. MTHI/MTLO write straight into HI/LO when the unit is idle.
//
// Ports
//   clk             : sole clock, rising-edge active
//   reset           : asynchronous active-low reset
//   start           : issue strobe; alu_control, operands and enables valid
//   alu_control[4:0]: MULT=10000 MULTU=10001 DIV=10010 DIVU=10011
//                     MTLO=10101 MTHI=10110, all other codes ignored
//   op_a[31:0]      : rs value (multiplicand / dividend / MTHI-MTLO source)
//   op_b[31:0]      : rt value (multiplier / divisor)
//   LO_write_enable : decoder permission to write LO
//   HI_write_enable : decoder permission to write HI
//   busy            : high while a multiply/divide is in flight
//   done            : one-cycle pulse when a multiply/divide completes
//   hi[31:0]        : HI register
//   lo[31:0]        : LO register

module hi_lo_muldiv #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alu_control,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        LO_write_enable,
    input  logic        HI_write_enable,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of a value, treating it as two's complement only when signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t      state_r, state_next_s;
    logic [4:0]  cnt_r, cnt_next_s;
    logic [63:0] acc_r, acc_next_s;
    logic [31:0] a_mag_r, a_mag_next_s;
    logic [31:0] b_mag_r, b_mag_next_s;
    logic        is_div_r, is_div_next_s;
    logic        neg_q_r, neg_q_next_s;   // negate product / quotient
    logic        neg_r_r, neg_r_next_s;   // negate remainder
    logic [31:0] hi_r, hi_next_s;
    logic [31:0] lo_r, lo_next_s;
    logic        busy_r;
    logic        done_r, done_next_s;

    logic        op_signed_s;
    logic        op_is_div_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_step_s;
    logic [32:0] div_trial_s;
    logic [63:0] div_step_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    // The opcode's low bit selects unsigned, bit 1 selects divide.
    assign op_signed_s = ~alu_control[0];
    assign op_is_div_s = alu_control[1];

    // One shift-add step: the multiplier lives in the low half and shifts out.
    assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_mag_r} : 33'd0);
    assign mul_step_s = {mul_sum_s, acc_r[31:1]};

    // One restoring step: bit 32 of the trial is set when the subtract borrows.
    assign div_trial_s = acc_r[63:31] - {1'b0, b_mag_r};
    assign div_step_s  = div_trial_s[32] ? {acc_r[62:0], 1'b0}
                                         : {div_trial_s[31:0], acc_r[30:0], 1'b1};

    // Sign fix-up applied in the FIX cycle.
    assign prod_fix_s = neg_q_r ? (64'd0 - acc_r) : acc_r;
    assign quo_fix_s  = neg_q_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
    assign rem_fix_s  = neg_r_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];

    // Next-state and datapath update logic.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        acc_next_s    = acc_r;
        a_mag_next_s  = a_mag_r;
        b_mag_next_s  = b_mag_r;
        is_div_next_s = is_div_r;
        neg_q_next_s  = neg_q_r;
        neg_r_next_s  = neg_r_r;
        hi_next_s     = hi_r;
        lo_next_s     = lo_r;
        done_next_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (alu_control)
                        OP_MTHI: begin
                            if (HI_write_enable) begin
                                hi_next_s = op_a;
                            end else begin
                                hi_next_s = hi_r;
                            end
                        end
                        OP_MTLO: begin
                            if (LO_write_enable) begin
                                lo_next_s = op_a;
                            end else begin
                                lo_next_s = lo_r;
                            end
                        end
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            if (HI_write_enable && LO_write_enable) begin
                                if (op_is_div_s && (op_b == 32'd0)) begin
                                    // Divide by zero: leave HI/LO alone, report completion.
                                    done_next_s = 1'b1;
                                end else begin
                                    a_mag_next_s  = mag32(op_a, op_signed_s);
                                    b_mag_next_s  = mag32(op_b, op_signed_s);
                                    is_div_next_s = op_is_div_s;
                                    neg_q_next_s  = op_signed_s & (op_a[31] ^ op_b[31]);
                                    neg_r_next_s  = op_signed_s & op_a[31];
                                    acc_next_s    = op_is_div_s ? {32'd0, mag32(op_a, op_signed_s)}
                                                                : {32'd0, mag32(op_b, op_signed_s)};
                                    cnt_next_s    = 5'd0;
                                    state_next_s  = ST_RUN;
                                end
                            end else begin
                                state_next_s = ST_IDLE;
                            end
                        end
                        default: begin
                            state_next_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_next_s = is_div_r ? div_step_s : mul_step_s;
                cnt_next_s = cnt_r + 5'd1;
                if (cnt_r == LAST_ITER) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX: begin
                if (is_div_r) begin
                    hi_next_s = rem_fix_s;
                    lo_next_s = quo_fix_s;
                end else begin
                    hi_next_s = prod_fix_s[63:32];
                    lo_next_s = prod_fix_s[31:0];
                end
                done_next_s  = 1'b1;
                cnt_next_s   = 5'd0;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            acc_r    <= 64'd0;
            a_mag_r  <= 32'd0;
            b_mag_r  <= 32'd0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            acc_r    <= acc_next_s;
            a_mag_r  <= a_mag_next_s;
            b_mag_r  <= b_mag_next_s;
            is_div_r <= is_div_next_s;
            neg_q_r  <= neg_q_next_s;
            neg_r_r  <= neg_r_next_s;
            hi_r     <= hi_next_s;
            lo_r     <= lo_next_s;
            busy_r   <= (state_next_s != ST_IDLE);
            done_r   <= done_next_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Directed self-checking bench for hi_lo_muldiv.
module tb_hi_lo_muldiv;

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        LO_write_enable;
    logic        HI_write_enable;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    hi_lo_muldiv #(.ITER(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .alu_control     (alu_control),
        .op_a            (op_a),
        .op_b            (op_b),
        .LO_write_enable (LO_write_enable),
        .HI_write_enable (HI_write_enable),
        .busy            (busy),
        .done            (done),
        .hi              (hi),
        .lo              (lo)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present one op at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hwe, input logic lwe);
        @(negedge clk);
        start = 1'b1; alu_control = op; op_a = a; op_b = b;
        HI_write_enable = hwe; LO_write_enable = lwe;
        @(posedge clk);
        #1;
        start = 1'b0; HI_write_enable = 1'b1; LO_write_enable = 1'b1;
    endtask

    // Sample each negedge until done; done_at==0 means the budget expired.
    task automatic wait_done(input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                             output int busy_cyc, output int done_at, output logic held_ok);
        busy_cyc = 0; done_at = 0; held_ok = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (busy && (hi !== hold_hi || lo !== hold_lo)) held_ok = 1'b0;
            if (done) begin
                done_at = i;
                break;
            end
        end
    endtask

    task automatic run_muldiv(input string tag, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo);
        int bc, da;
        logic ok;
        logic [31:0] old_hi, old_lo;
        old_hi = hi; old_lo = lo;
        issue(op, a, b, 1'b1, 1'b1);
        wait_done(old_hi, old_lo, bc, da, ok);
        check_value({tag, "_busy_cycles"}, 32'(bc), 32'd33);
        check_value({tag, "_done_latency"}, 32'(da), 32'd34);
        check_value({tag, "_held_in_run"}, {31'd0, ok}, 32'd1);
        check_value({tag, "_hi"}, hi, exp_hi);
        check_value({tag, "_lo"}, lo, exp_lo);
        @(negedge clk);
        check_value({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int bc, da;
        logic ok;
        reset = 1'b0; start = 1'b0; alu_control = 5'd0; op_a = 32'd0; op_b = 32'd0;
        HI_write_enable = 1'b1; LO_write_enable = 1'b1;
        #1;
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_done", {31'd0, done}, 32'd0);
        check_value("rst_hi", hi, 32'd0);
        check_value("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // First op after reset, move-to registers and write gating.
        issue(OP_MTHI, 32'h0000_1234, 32'd0, 1'b1, 1'b1);
        check_value("mthi_hi", hi, 32'h0000_1234);
        check_value("mthi_busy", {31'd0, busy}, 32'd0);
        check_value("mthi_done", {31'd0, done}, 32'd0);
        issue(OP_MTLO, 32'h0000_5678, 32'd0, 1'b1, 1'b1);
        check_value("mtlo_lo", lo, 32'h0000_5678);
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        check_value("mthi_gated", hi, 32'h0000_1234);
        issue(5'b00000, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
        check_value("bad_code_busy", {31'd0, busy}, 32'd0);
        check_value("bad_code_lo", lo, 32'h0000_5678);

        // Divide by zero: no run, results unchanged, done next cycle.
        issue(OP_DIV, 32'd9, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        check_value("div0_done", {31'd0, done}, 32'd1);
        check_value("div0_busy", {31'd0, busy}, 32'd0);
        check_value("div0_hi", hi, 32'h0000_1234);
        check_value("div0_lo", lo, 32'h0000_5678);
        @(negedge clk);
        check_value("div0_done_clr", {31'd0, done}, 32'd0);

        run_muldiv("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_muldiv("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_muldiv("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_muldiv("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_muldiv("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_muldiv("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);

        // Mul/div disabled by a cleared enable is ignored.
        issue(OP_MULTU, 32'd2, 32'd2, 1'b1, 1'b0);
        check_value("mul_noen_busy", {31'd0, busy}, 32'd0);

        // Ops issued while a MULT is running are dropped.
        issue(OP_MULT, 32'd6, 32'd7, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; alu_control = OP_MTHI; op_a = 32'h0000_AAAA;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        start = 1'b1; alu_control = OP_DIVU; op_a = 32'd100; op_b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        wait_done(32'h0000_FFFF, 32'h0000_FFFF, bc, da, ok);
        check_value("inflight_done_seen", {31'd0, (da != 0)}, 32'd1);
        check_value("inflight_hi", hi, 32'd0);
        check_value("inflight_lo", lo, 32'd42);
        @(negedge clk);
        check_value("inflight_no_second", {31'd0, busy}, 32'd0);

        // MTHI presented during the FIX cycle is dropped.
        issue(OP_MULTU, 32'd2, 32'd3, 1'b1, 1'b1);
        repeat (33) @(negedge clk);
        check_value("fix_busy", {31'd0, busy}, 32'd1);
        start = 1'b1; alu_control = OP_MTHI; op_a = 32'h0000_BBBB;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check_value("fix_done", {31'd0, done}, 32'd1);
        check_value("fix_hi", hi, 32'd0);
        check_value("fix_lo", lo, 32'd6);

        // Reset mid-run aborts with no result and no done pulse.
        issue(OP_MTHI, 32'h0000_0055, 32'd0, 1'b1, 1'b1);
        issue(OP_MULTU, 32'd5, 32'd5, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #2;
        check_value("abort_busy", {31'd0, busy}, 32'd0);
        check_value("abort_hi", hi, 32'd0);
        check_value("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) ok = 1'b0;
        end
        check_value("abort_quiet", {31'd0, ok}, 32'd1);
        run_muldiv("after_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
